io_ctrl: RTL and testbench

IO_CTRL -- requirements
Module: io_ctrl

---
 rtl/io_pkg.sv | 12 +
 rtl/io_ctrl_byte_fifo.sv | 75 +++++++
 rtl/io_ctrl.sv | 124 ++++++++++++
 tb/tb_io_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared types and constants for the cin/cout byte-stream controller.
package io_pkg;
    typedef enum logic [1:0] {
        IN_IDLE = 2'd0,
        IN_WAIT = 2'd1,
        IN_DONE = 2'd2
    } in_state_e;

    localparam int RX_DEPTH_LOG2_DEF = 4;
    localparam int TX_DEPTH_LOG2_DEF = 4;
    localparam int N_LANES           = 4;
endpackage

// File: rtl/io_ctrl_byte_fifo.sv
// Byte FIFO with single-byte and whole-word (4 byte) push/pop; word lanes are little-endian.
module byte_fifo
    import io_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int OUT_BYTES  = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push1,
    input  logic [7:0]             din1,
    input  logic                   push4,
    input  logic [31:0]            din4,
    input  logic                   pop1,
    input  logic                   pop4,
    output logic [8*OUT_BYTES-1:0] dout,
    output logic [DEPTH_LOG2:0]    count
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;
    typedef logic [DEPTH_LOG2-1:0] ptr_t;

    logic [7:0] mem_q [DEPTH];
    logic [7:0] mem_d [DEPTH];
    ptr_t       wr_ptr_q, wr_ptr_d;
    ptr_t       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // A push landing on a full FIFO overwrites the slot being popped this cycle,
    // which is safe because dout reads the pre-edge contents.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push1) begin
            mem_d[wr_ptr_d] = din1;
            wr_ptr_d        = wr_ptr_d + ptr_t'(1);
        end
        if (push4) begin
            for (int i = 0; i < N_LANES; i++) begin
                mem_d[wr_ptr_d + ptr_t'(i)] = din4[8*i +: 8];
            end
            wr_ptr_d = wr_ptr_d + ptr_t'(N_LANES);
        end
        if (pop1) rd_ptr_d = rd_ptr_d + ptr_t'(1);
        if (pop4) rd_ptr_d = rd_ptr_d + ptr_t'(N_LANES);
        count_d = count_q + CW'(push1) + (push4 ? CW'(N_LANES) : CW'(0))
                          - CW'(pop1)  - (pop4  ? CW'(N_LANES) : CW'(0));
    end

    always_comb begin
        dout = '0;
        for (int i = 0; i < OUT_BYTES; i++) begin
            dout[8*i +: 8] = mem_q[rd_ptr_q + ptr_t'(i)];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign count = count_q;
endmodule

// File: rtl/io_ctrl.sv
// cin/cout bridge between the exec stage and a UART byte stream.
// Optional sticky RX overflow flag: define IO_RX_OVERFLOW_FLAG_EN.
module io_ctrl
    import io_pkg::*;
#(
    parameter int RX_DEPTH_LOG2 = RX_DEPTH_LOG2_DEF,
    parameter int TX_DEPTH_LOG2 = TX_DEPTH_LOG2_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_req_e,
    input  logic        out_req_e,
    input  logic [31:0] out_data_e,
    output logic [31:0] in_data,
    output logic        in_stall,
    output logic        out_stall,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        rx_overflow
);
    localparam int RXCW = RX_DEPTH_LOG2 + 1;
    localparam int TXCW = TX_DEPTH_LOG2 + 1;
    localparam logic [RXCW-1:0] RX_DEPTH_C = RXCW'(1 << RX_DEPTH_LOG2);
    localparam logic [TXCW-1:0] TX_DEPTH_C = TXCW'(1 << TX_DEPTH_LOG2);
    localparam logic [RXCW-1:0] RX_LANES_C = RXCW'(N_LANES);
    localparam logic [TXCW-1:0] TX_LANES_C = TXCW'(N_LANES);

    in_state_e     state_q, state_d;
    logic [31:0]   in_data_q, in_data_d;
    logic          in_stall_fsm;
    logic          rx_pop4, rx_push, rx_full;
    logic [31:0]   rx_head;
    logic [RXCW-1:0] rx_count;
    logic          tx_push4, tx_pop1;
    logic [TXCW-1:0] tx_count, tx_free;

    always_comb begin
        state_d      = state_q;
        in_stall_fsm = 1'b0;
        rx_pop4      = 1'b0;
        unique case (state_q)
            IN_IDLE: begin
                if (in_req_e) begin
                    in_stall_fsm = 1'b1;
                    state_d      = IN_WAIT;
                end
            end
            IN_WAIT: begin
                in_stall_fsm = 1'b1;
                if (rx_count >= RX_LANES_C) begin
                    rx_pop4 = 1'b1;
                    state_d = IN_DONE;
                end
            end
            IN_DONE: state_d = IN_IDLE;
            default: state_d = IN_IDLE;
        endcase
        in_data_d = rx_pop4 ? rx_head : in_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IN_IDLE;
            in_data_q <= '0;
        end else begin
            state_q   <= state_d;
            in_data_q <= in_data_d;
        end
    end

    // A same-cycle word pop frees room, so a byte arriving on a full FIFO is kept.
    assign rx_full  = (rx_count == RX_DEPTH_C);
    assign rx_push  = rx_valid & (~rx_full | rx_pop4);
    assign in_stall = in_stall_fsm & ~rst;
    assign in_data  = in_data_q;

    byte_fifo #(.DEPTH_LOG2(RX_DEPTH_LOG2), .OUT_BYTES(N_LANES)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push1 (rx_push),
        .din1  (rx_data),
        .push4 (1'b0),
        .din4  (32'h0),
        .pop1  (1'b0),
        .pop4  (rx_pop4),
        .dout  (rx_head),
        .count (rx_count)
    );

`ifdef IO_RX_OVERFLOW_FLAG_EN
    logic rx_overflow_q, rx_overflow_d;
    assign rx_overflow_d = rx_overflow_q | (rx_valid & ~rx_push);
    always_ff @(posedge clk) begin
        if (rst) rx_overflow_q <= 1'b0;
        else     rx_overflow_q <= rx_overflow_d;
    end
    assign rx_overflow = rx_overflow_q;
`else
    assign rx_overflow = 1'b0;
`endif

    // Free space is judged before this cycle's pop; the push waits one more cycle.
    assign tx_free   = TX_DEPTH_C - tx_count;
    assign out_stall = out_req_e & (tx_free < TX_LANES_C) & ~rst;
    assign tx_push4  = out_req_e & ~out_stall;
    assign tx_valid  = (tx_count != '0);
    assign tx_pop1   = tx_valid & tx_ready;

    byte_fifo #(.DEPTH_LOG2(TX_DEPTH_LOG2), .OUT_BYTES(1)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push1 (1'b0),
        .din1  (8'h0),
        .push4 (tx_push4),
        .din4  (out_data_e),
        .pop1  (tx_pop1),
        .pop4  (1'b0),
        .dout  (tx_data),
        .count (tx_count)
    );
endmodule

// File: tb/tb_io_ctrl.sv
// Directed vector bench for io_ctrl (default depths 16/16).
module tb_io_ctrl;
`ifdef IO_RX_OVERFLOW_FLAG_EN
    localparam logic OVF_EN = 1'b1;
`else
    localparam logic OVF_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_req_e = 1'b0, out_req_e = 1'b0;
    logic [31:0] out_data_e = '0;
    logic [31:0] in_data;
    logic        in_stall, out_stall;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        rx_overflow;

    io_ctrl dut (
        .clk(clk), .rst(rst),
        .in_req_e(in_req_e), .out_req_e(out_req_e), .out_data_e(out_data_e),
        .in_data(in_data), .in_stall(in_stall), .out_stall(out_stall),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_overflow(rx_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        in_req;
        logic        out_req;
        logic [31:0] out_data;
        logic        rx_v;
        logic [7:0]  rx_d;
        logic        tx_rdy;
        logic        e_in_stall;
        logic        e_out_stall;
        logic        e_tx_valid;
        logic [7:0]  e_tx_data;
        logic        chk_in;
        logic [31:0] e_in_data;
    } vec_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   step    = 0;
    logic ovf_exp = 1'b0;
    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic ir, input logic orq, input logic [31:0] od,
                                input logic rv, input logic [7:0] rd, input logic tr,
                                input logic eis, input logic eos, input logic etv,
                                input logic [7:0] etd, input logic ci, input logic [31:0] eid);
        vec_t v;
        v.in_req = ir;  v.out_req = orq; v.out_data = od;
        v.rx_v = rv;    v.rx_d = rd;     v.tx_rdy = tr;
        v.e_in_stall = eis; v.e_out_stall = eos; v.e_tx_valid = etv;
        v.e_tx_data = etd;  v.chk_in = ci;       v.e_in_data = eid;
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        in_req_e = v.in_req; out_req_e = v.out_req; out_data_e = v.out_data;
        rx_valid = v.rx_v;   rx_data = v.rx_d;      tx_ready = v.tx_rdy;
        #1;
        check($sformatf("in_stall@%0d", step), {31'b0, in_stall}, {31'b0, v.e_in_stall});
        check($sformatf("out_stall@%0d", step), {31'b0, out_stall}, {31'b0, v.e_out_stall});
        check($sformatf("tx_valid@%0d", step), {31'b0, tx_valid}, {31'b0, v.e_tx_valid});
        if (v.e_tx_valid) check($sformatf("tx_data@%0d", step), {24'b0, tx_data}, {24'b0, v.e_tx_data});
        if (v.chk_in)     check($sformatf("in_data@%0d", step), in_data, v.e_in_data);
        check($sformatf("rx_overflow@%0d", step), {31'b0, rx_overflow}, {31'b0, ovf_exp});
        step++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_req_e = 1'b0; out_req_e = 1'b0; out_data_e = '0;
        rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b0;
        #1;
        check("rst_in_stall", {31'b0, in_stall}, 32'h0);
        check("rst_out_stall", {31'b0, out_stall}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        ovf_exp = 1'b0;
    endtask

    // cin of a word already buffered: stall, stall(pop), done
    task automatic cin_ready(input logic [31:0] exp);
        run_vec(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        run_vec(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        run_vec(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [31:0] w;
        logic [31:0] wd;
        logic [7:0]  bseq [4];
        do_reset();
        do_reset();

        // cin with 4 bytes already buffered
        tbl.push_back(mk(0, 0, 0, 1, 8'h78, 0, 0, 0, 0, 0, 1, 32'h0));
        tbl.push_back(mk(0, 0, 0, 1, 8'h56, 0, 0, 0, 0, 0, 1, 32'h0));
        tbl.push_back(mk(0, 0, 0, 1, 8'h34, 0, 0, 0, 0, 0, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 1, 8'h12, 0, 0, 0, 0, 0, 0, 32'h0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 32'h0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h12345678));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h12345678));
        // cin on empty RX, bytes 5 cycles apart
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        bseq = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int c = 1; c <= 17; c++) begin
            if (c % 5 == 1) tbl.push_back(mk(1, 0, 0, 1, bseq[c/5], 0, 1, 0, 0, 0, 0, 0));
            else            tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        end
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h44332211));
        // cout with transmitter ready
        tbl.push_back(mk(0, 1, 32'hDEADBEEF, 0, 0, 1, 0, 0, 0, 0, 1, 32'h44332211));
        bseq = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        for (int b = 0; b < 4; b++) tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, bseq[b], 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));

        foreach (tbl[i]) run_vec(tbl[i]);

        // TX: fill to 16, drain 3 to 13, cout stalls, one pop releases it
        for (int k = 0; k < 4; k++) begin
            w  = 32'hA0B0C0D0 + k * 32'h01010101;
            wd = 32'hA0B0C0D0;
            run_vec(mk(0, 1, w, 0, 0, 0, 0, 0, k > 0, wd[7:0], 0, 0));
        end
        wd = 32'hA0B0C0D0;
        for (int j = 0; j < 3; j++) run_vec(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, wd[8*j +: 8], 0, 0));
        w = 32'hA0B0C0D0 + 4 * 32'h01010101;
        run_vec(mk(0, 1, w, 0, 0, 0, 0, 1, 1, wd[31:24], 0, 0));
        run_vec(mk(0, 1, w, 0, 0, 1, 0, 1, 1, wd[31:24], 0, 0));
        wd = 32'hA0B0C0D0 + 32'h01010101;
        run_vec(mk(0, 1, w, 0, 0, 0, 0, 0, 1, wd[7:0], 0, 0));
        for (int k = 1; k <= 4; k++) begin
            wd = 32'hA0B0C0D0 + k * 32'h01010101;
            for (int b = 0; b < 4; b++) run_vec(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, wd[8*b +: 8], 0, 0));
        end
        run_vec(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));

        // RX: fill 16, drop 17th, push on full during pop is kept
        for (int i = 0; i < 16; i++) run_vec(mk(0, 0, 0, 1, 8'(i), 0, 0, 0, 0, 0, 0, 0));
        run_vec(mk(0, 0, 0, 1, 8'hEE, 0, 0, 0, 0, 0, 0, 0));
        ovf_exp = OVF_EN;
        run_vec(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        run_vec(mk(1, 0, 0, 1, 8'h10, 0, 1, 0, 0, 0, 0, 0));
        run_vec(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h03020100));
        cin_ready(32'h07060504);
        cin_ready(32'h0B0A0908);
        cin_ready(32'h0F0E0D0C);
        run_vec(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        run_vec(mk(1, 0, 0, 1, 8'h11, 0, 1, 0, 0, 0, 0, 0));
        run_vec(mk(1, 0, 0, 1, 8'h12, 0, 1, 0, 0, 0, 0, 0));
        run_vec(mk(1, 0, 0, 1, 8'h13, 0, 1, 0, 0, 0, 0, 0));
        run_vec(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        run_vec(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h13121110));
        run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h13121110));
        do_reset();
        run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0));

        // reset while waiting with 2 bytes buffered
        run_vec(mk(0, 0, 0, 1, 8'h55, 0, 0, 0, 0, 0, 0, 0));
        run_vec(mk(0, 0, 0, 1, 8'h66, 0, 0, 0, 0, 0, 0, 0));
        run_vec(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        run_vec(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst = 1'b1; in_req_e = 1'b1; rx_valid = 1'b1; rx_data = 8'h99;
        #1;
        check("rst_wait_in_stall", {31'b0, in_stall}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        run_vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0));
        run_vec(mk(0, 0, 0, 1, 8'hA0, 0, 0, 0, 0, 0, 0, 0));
        run_vec(mk(0, 0, 0, 1, 8'hA1, 0, 0, 0, 0, 0, 0, 0));
        run_vec(mk(0, 0, 0, 1, 8'hA2, 0, 0, 0, 0, 0, 0, 0));
        run_vec(mk(0, 0, 0, 1, 8'hA3, 0, 0, 0, 0, 0, 0, 0));
        cin_ready(32'hA3A2A1A0);
        run_vec(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 32'hA3A2A1A0));
        run_vec(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 32'hA3A2A1A0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
